// File: rtl/nv_nvdla_mcif_read_eg_rr_arb.sv
// Round-robin read-return merger with burst lock feeding one registered output stage.
// A source that wins with a non-last beat owns the output until its last beat is taken.
module nv_nvdla_mcif_read_eg_rr_arb #(
  parameter int PD_WIDTH = 514,
  parameter int NUM_SRC  = 4,
  parameter int SRC_ID_W = 2
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rstn,
  input  logic [NUM_SRC-1:0]           src_vld,
  input  logic [NUM_SRC-1:0]           src_last,
  input  logic [NUM_SRC*PD_WIDTH-1:0]  src_pd,
  output logic [NUM_SRC-1:0]           src_rdy,
  input  logic [NUM_SRC-1:0]           arb_en_mask,
  output logic                         out_vld,
  output logic [PD_WIDTH-1:0]          out_pd,
  output logic                         out_last,
  output logic [SRC_ID_W-1:0]          out_src_id,
  input  logic                         out_rdy,
  input  logic                         cnt_clr,
  output logic [31:0]                  cnt_stall
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  localparam logic [SRC_ID_W-1:0] RR_RST = SRC_ID_W'(NUM_SRC - 1);

  lock_state_e         state, state_nxt;
  logic [SRC_ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [SRC_ID_W-1:0] lock_id, lock_id_nxt;
  logic [SRC_ID_W-1:0] grant_id;
  logic                grant_vld;
  logic                load_en;
  logic                accept;
  logic                accept_last;

  // Unlocked: first valid and enabled source after rr_ptr; locked: lock_id only.
  always_comb begin
    int unsigned         idx;
    logic [SRC_ID_W-1:0] idx_w;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    idx_w     = '0;
    if (state == LOCKED) begin
      grant_vld = src_vld[lock_id];
      grant_id  = lock_id;
    end else begin
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
        idx   = (32'(rr_ptr) + k) % NUM_SRC;
        idx_w = SRC_ID_W'(idx);
        if (!grant_vld && src_vld[idx_w] && arb_en_mask[idx_w]) begin
          grant_vld = 1'b1;
          grant_id  = idx_w;
        end
      end
    end
  end

  assign load_en     = !out_vld || out_rdy;
  assign accept      = grant_vld && load_en;
  assign accept_last = src_last[grant_id];

  always_comb begin
    src_rdy = '0;
    if (accept) begin
      src_rdy[grant_id] = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    lock_id_nxt = lock_id;
    case (state)
      UNLOCKED: begin
        if (accept) begin
          if (accept_last) begin
            rr_ptr_nxt = grant_id;
          end else begin
            state_nxt   = LOCKED;
            lock_id_nxt = grant_id;
          end
        end
      end
      LOCKED: begin
        if (accept && accept_last) begin
          state_nxt  = UNLOCKED;
          rr_ptr_nxt = lock_id;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state   <= UNLOCKED;
      rr_ptr  <= RR_RST;
      lock_id <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      lock_id <= lock_id_nxt;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_vld    <= 1'b0;
      out_last   <= 1'b0;
      out_src_id <= '0;
    end else if (accept) begin
      out_vld    <= 1'b1;
      out_last   <= accept_last;
      out_src_id <= grant_id;
    end else if (out_rdy) begin
      out_vld    <= 1'b0;
    end
  end

  // Payload register is deliberately reset-free; it is only meaningful under out_vld.
  always_ff @(posedge nvdla_core_clk) begin
    if (accept) begin
      out_pd <= src_pd[grant_id*PD_WIDTH +: PD_WIDTH];
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt_stall <= '0;
    end else if (cnt_clr) begin
      cnt_stall <= '0;
    end else if (out_vld && !out_rdy && (cnt_stall != '1)) begin
      cnt_stall <= cnt_stall + 32'd1;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_mcif_read_eg_rr_arb.sv
// Bench for the round-robin burst-lock read-return arbiter: vector table plus payload scoreboard,
// with hand sequences for output stall, stall counter clear and asynchronous reset mid-burst.
module tb_nv_nvdla_mcif_read_eg_rr_arb;

  localparam int PD_WIDTH = 514;
  localparam int NUM_SRC  = 4;
  localparam int SRC_ID_W = 2;

  logic                        clk;
  logic                        rstn;
  logic [NUM_SRC-1:0]          src_vld;
  logic [NUM_SRC-1:0]          src_last;
  logic [NUM_SRC*PD_WIDTH-1:0] src_pd;
  logic [NUM_SRC-1:0]          src_rdy;
  logic [NUM_SRC-1:0]          arb_en_mask;
  logic                        out_vld;
  logic [PD_WIDTH-1:0]         out_pd;
  logic                        out_last;
  logic [SRC_ID_W-1:0]         out_src_id;
  logic                        out_rdy;
  logic                        cnt_clr;
  logic [31:0]                 cnt_stall;

  nv_nvdla_mcif_read_eg_rr_arb #(
    .PD_WIDTH(PD_WIDTH),
    .NUM_SRC (NUM_SRC),
    .SRC_ID_W(SRC_ID_W)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .src_vld        (src_vld),
    .src_last       (src_last),
    .src_pd         (src_pd),
    .src_rdy        (src_rdy),
    .arb_en_mask    (arb_en_mask),
    .out_vld        (out_vld),
    .out_pd         (out_pd),
    .out_last       (out_last),
    .out_src_id     (out_src_id),
    .out_rdy        (out_rdy),
    .cnt_clr        (cnt_clr),
    .cnt_stall      (cnt_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] last;
    logic [3:0] mask;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ovld;
    logic [1:0] exp_id;
    logic       exp_last;
  } vec_t;

  vec_t                vecs[$];
  logic [PD_WIDTH-1:0] sb[$];
  logic [7:0]          seq[NUM_SRC];
  int unsigned         n_vec;
  int unsigned         n_err;
  logic [PD_WIDTH-1:0] held;

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [3:0] m,
                              input logic r, input logic [3:0] er, input logic eo,
                              input logic [1:0] ei, input logic el);
    vec_t t;
    t.vld = v; t.last = l; t.mask = m; t.ordy = r;
    t.exp_rdy = er; t.exp_ovld = eo; t.exp_id = ei; t.exp_last = el;
    return t;
  endfunction

  function automatic logic [PD_WIDTH-1:0] mkpd(input int s, input logic [7:0] q);
    logic [PD_WIDTH-1:0] p;
    p = '0;
    p[7:0]  = q;
    p[15:8] = 8'(s);
    p[PD_WIDTH-1 -: 8] = ~(8'(s)) ^ q;
    return p;
  endfunction

  function automatic int oh2i(input logic [3:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < NUM_SRC; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_pd(input string name, input logic [PD_WIDTH-1:0] act,
                        input logic [PD_WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name);
    logic [PD_WIDTH-1:0] e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no expected beat queued, got %h", name, out_pd);
    end else begin
      e = sb.pop_front();
      chk_pd(name, out_pd, e);
    end
  endtask

  // Drive one cycle of inputs, check combinational ready, queue the expected beat, step past the edge.
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [3:0] m,
                       input logic r, input logic c, input logic [3:0] er);
    int idx;
    src_vld = v; src_last = l; arb_en_mask = m; out_rdy = r; cnt_clr = c;
    for (int i = 0; i < NUM_SRC; i++) src_pd[i*PD_WIDTH +: PD_WIDTH] = mkpd(i, seq[i]);
    #2;
    chk("src_rdy", 64'(src_rdy), 64'(er));
    if (er != 4'b0000) begin
      idx = oh2i(er);
      sb.push_back(mkpd(idx, seq[idx]));
      seq[idx] = seq[idx] + 8'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    src_vld = '0; src_last = '0; src_pd = '0; arb_en_mask = '1; out_rdy = 1'b0; cnt_clr = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) seq[i] = 8'(i * 16);

    //                vld      last     mask     rdy  exp_rdy  ovld id  last
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b1111, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0, 1));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 1));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2, 1));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b1111, 1, 4'b1000, 1, 3, 1));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0, 1));
    // src0 4-beat burst while src1 waits
    vecs.push_back(mk(4'b1000, 4'b1000, 4'b1111, 1, 4'b1000, 1, 3, 1));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b1111, 1, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b1111, 1, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b1111, 1, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(4'b0011, 4'b0001, 4'b1111, 1, 4'b0001, 1, 0, 1));
    vecs.push_back(mk(4'b0010, 4'b0010, 4'b1111, 1, 4'b0010, 1, 1, 1));
    // mask 1011: source 2 skipped
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b1011, 1, 4'b1000, 1, 3, 1));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b1011, 1, 4'b0001, 1, 0, 1));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b1011, 1, 4'b0010, 1, 1, 1));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b1011, 1, 4'b1000, 1, 3, 1));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b1011, 1, 4'b0001, 1, 0, 1));
    // mask bit 0 cleared mid src0 burst
    vecs.push_back(mk(4'b1000, 4'b1000, 4'b1011, 1, 4'b1000, 1, 3, 1));
    vecs.push_back(mk(4'b1011, 4'b0000, 4'b1011, 1, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(4'b1011, 4'b0000, 4'b1010, 1, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(4'b1011, 4'b0001, 4'b1010, 1, 4'b0001, 1, 0, 1));
    vecs.push_back(mk(4'b1011, 4'b1111, 4'b1010, 1, 4'b0010, 1, 1, 1));
    vecs.push_back(mk(4'b1011, 4'b1111, 4'b1010, 1, 4'b1000, 1, 3, 1));
    vecs.push_back(mk(4'b1011, 4'b1111, 4'b1010, 1, 4'b0010, 1, 1, 1));
    // src3 locked, drops valid for 3 cycles while src1 waits
    vecs.push_back(mk(4'b1010, 4'b0000, 4'b1111, 1, 4'b1000, 1, 3, 0));
    vecs.push_back(mk(4'b0010, 4'b0010, 4'b1111, 1, 4'b0000, 0, 3, 0));
    vecs.push_back(mk(4'b0010, 4'b0010, 4'b1111, 1, 4'b0000, 0, 3, 0));
    vecs.push_back(mk(4'b0010, 4'b0010, 4'b1111, 1, 4'b0000, 0, 3, 0));
    vecs.push_back(mk(4'b1010, 4'b1000, 4'b1111, 1, 4'b1000, 1, 3, 1));
    vecs.push_back(mk(4'b0010, 4'b0010, 4'b1111, 1, 4'b0010, 1, 1, 1));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b1111, 1, 4'b0000, 0, 1, 1));

    #3;
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_src_id", 64'(out_src_id), 64'd0);
    chk("rst_cnt_stall", 64'(cnt_stall), 64'd0);
    #9;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].last, vecs[i].mask, vecs[i].ordy, 1'b0, vecs[i].exp_rdy);
      chk("out_vld", 64'(out_vld), 64'(vecs[i].exp_ovld));
      chk("out_src_id", 64'(out_src_id), 64'(vecs[i].exp_id));
      chk("out_last", 64'(out_last), 64'(vecs[i].exp_last));
      if (vecs[i].exp_rdy != 4'b0000) chk_beat("out_pd");
    end

    // Downstream stall: payload holds, no source is readied, counter counts 5 then clears.
    drive(4'b0001, 4'b0001, 4'b1111, 1'b0, 1'b0, 4'b0001);
    held = sb[0];
    chk("stall_load_vld", 64'(out_vld), 64'd1);
    chk_beat("stall_load_pd");
    chk("stall_cnt_start", cnt_stall, 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100, 4'b0100, 4'b1111, 1'b0, 1'b0, 4'b0000);
      chk("stall_vld", 64'(out_vld), 64'd1);
      chk("stall_id", 64'(out_src_id), 64'd0);
      chk_pd("stall_pd_hold", out_pd, held);
    end
    chk("stall_cnt", cnt_stall, 64'd5);
    drive(4'b0100, 4'b0100, 4'b1111, 1'b1, 1'b1, 4'b0100);
    chk("cnt_clr", cnt_stall, 64'd0);
    chk("after_stall_id", 64'(out_src_id), 64'd2);
    chk_beat("after_stall_pd");

    // Asynchronous reset during a locked burst with the output held valid.
    drive(4'b0010, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0010);
    chk("lock_id", 64'(out_src_id), 64'd1);
    chk("lock_last", 64'(out_last), 64'd0);
    chk_beat("lock_pd");
    out_rdy = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_async_vld", 64'(out_vld), 64'd0);
    chk("rst_async_cnt", cnt_stall, 64'd0);
    #1;
    rstn = 1'b1;
    drive(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001);
    chk("post_rst_vld", 64'(out_vld), 64'd1);
    chk("post_rst_id", 64'(out_src_id), 64'd0);
    chk_beat("post_rst_pd");
    drive(4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000);
    chk("idle_vld", 64'(out_vld), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_vec);
    $fatal(1, "timeout");
  end

endmodule
